// File: rtl/loop_test_ctrl_if.sv
// Interface bundling the register-side controls and the loop-checker-side
// signals of loop_test_ctrl. The slave modport is the controller view and the
// master modport is the CPU/checker (or testbench) view.
interface loop_test_ctrl_if #(
   parameter int DWIDTH = 8,
   parameter int CWIDTH = 16
);
   logic              start_i;
   logic [DWIDTH-1:0] seed_i;
   logic [CWIDTH-1:0] count_i;
   logic [CWIDTH-1:0] gap_i;
   logic              rx_stb_i;
   logic [4:0]        rx_errors_i;

   logic              chk_rst_o;
   logic [DWIDTH-1:0] seed_o;
   logic              tx_stb_o;
   logic              busy_o;
   logic              done_o;
   logic              pass_o;
   logic              timeout_o;
   logic [4:0]        errors_o;
   logic [CWIDTH-1:0] rx_count_o;

   modport slave (
      input  start_i, seed_i, count_i, gap_i, rx_stb_i, rx_errors_i,
      output chk_rst_o, seed_o, tx_stb_o, busy_o, done_o, pass_o, timeout_o,
             errors_o, rx_count_o
   );

   modport master (
      output start_i, seed_i, count_i, gap_i, rx_stb_i, rx_errors_i,
      input  chk_rst_o, seed_o, tx_stb_o, busy_o, done_o, pass_o, timeout_o,
             errors_o, rx_count_o
   );
endinterface

// File: rtl/loop_test_ctrl.sv
// loop_test_ctrl: sequences one loopback test on the loop checker.
// Flow: IDLE -> RESET (checker reset) -> SEND (paced TX strobes) -> DRAIN
// (wait for RX to catch up or time out) -> CHECK (latch errors/verdict) -> DONE.
// A zero word count goes IDLE -> CHECK -> DONE and reports NOT_RX.
// Optional build macro LOOP_TEST_STOP_ON_ERR_EN: a value-mismatch error
// (rx_errors_i[1]) during SEND or DRAIN aborts straight to CHECK.
module loop_test_ctrl #(
   parameter int DWIDTH     = 8,
   parameter int CWIDTH     = 16,
   parameter int RST_CYCLES = 4,
   parameter int TIMEOUT    = 1024
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   loop_test_ctrl_if.slave       bus
);

   localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam int TW = $clog2(TIMEOUT);

   localparam logic [RW-1:0]     RST_LAST = RW'(RST_CYCLES - 1);
   localparam logic [TW-1:0]     TO_LAST  = TW'(TIMEOUT - 1);
   localparam logic [CWIDTH-1:0] C_ONE    = CWIDTH'(1);
   localparam logic [CWIDTH-1:0] C_ZERO   = CWIDTH'(0);
   localparam logic [CWIDTH-1:0] C_MAX    = {CWIDTH{1'b1}};

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RESET = 3'd1,
      ST_SEND  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_CHECK = 3'd4,
      ST_DONE  = 3'd5
   } state_t;

   state_t            state_q;
   logic [DWIDTH-1:0] seed_q;
   logic [CWIDTH-1:0] count_q;
   logic [CWIDTH-1:0] gap_q;
   logic [CWIDTH-1:0] sent_q;
   logic [CWIDTH-1:0] gap_cnt_q;
   logic [RW-1:0]     rst_cnt_q;
   logic [TW-1:0]     drain_cnt_q;
   logic [CWIDTH-1:0] rx_cnt_q;
   logic [CWIDTH-1:0] rx_cnt_d;
   logic              chk_rst_q;
   logic              tx_stb_q;
   logic              busy_q;
   logic              done_q;
   logic              pass_q;
   logic              timeout_q;
   logic [4:0]        errors_q;
   logic              zero_q;
   logic              abort_q;
   logic              abort_s;

`ifdef LOOP_TEST_STOP_ON_ERR_EN
   assign abort_s = bus.rx_errors_i[1];
`else
   assign abort_s = 1'b0;
`endif

   // Saturating RX strobe counter next value; only counts while SEND or DRAIN.
   always_comb begin
      rx_cnt_d = rx_cnt_q;
      if (((state_q == ST_SEND) || (state_q == ST_DRAIN)) && bus.rx_stb_i && (rx_cnt_q != C_MAX)) begin
         rx_cnt_d = rx_cnt_q + C_ONE;
      end else begin
         rx_cnt_d = rx_cnt_q;
      end
   end

   // Test sequencer with all outputs registered.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         seed_q      <= '0;
         count_q     <= '0;
         gap_q       <= '0;
         sent_q      <= '0;
         gap_cnt_q   <= '0;
         rst_cnt_q   <= '0;
         drain_cnt_q <= '0;
         rx_cnt_q    <= '0;
         chk_rst_q   <= 1'b0;
         tx_stb_q    <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         timeout_q   <= 1'b0;
         errors_q    <= 5'b00000;
         zero_q      <= 1'b0;
         abort_q     <= 1'b0;
      end else begin
         rx_cnt_q <= rx_cnt_d;
         done_q   <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (bus.start_i) begin
                  seed_q      <= bus.seed_i;
                  count_q     <= bus.count_i;
                  gap_q       <= bus.gap_i;
                  sent_q      <= C_ZERO;
                  gap_cnt_q   <= C_ZERO;
                  rst_cnt_q   <= RW'(0);
                  drain_cnt_q <= TW'(0);
                  rx_cnt_q    <= C_ZERO;
                  pass_q      <= 1'b0;
                  timeout_q   <= 1'b0;
                  errors_q    <= 5'b00000;
                  abort_q     <= 1'b0;
                  busy_q      <= 1'b1;
                  if (bus.count_i == C_ZERO) begin
                     // Nothing to send: report NOT_RX without touching the checker.
                     zero_q  <= 1'b1;
                     state_q <= ST_CHECK;
                  end else begin
                     zero_q    <= 1'b0;
                     chk_rst_q <= 1'b1;
                     state_q   <= ST_RESET;
                  end
               end else begin
                  state_q <= ST_IDLE;
               end
            end

            ST_RESET: begin
               if (rst_cnt_q == RST_LAST) begin
                  // Release the checker and issue the first strobe immediately.
                  chk_rst_q <= 1'b0;
                  tx_stb_q  <= 1'b1;
                  sent_q    <= C_ONE;
                  gap_cnt_q <= C_ZERO;
                  state_q   <= ST_SEND;
               end else begin
                  rst_cnt_q <= rst_cnt_q + RW'(1);
               end
            end

            ST_SEND: begin
               if (abort_s) begin
                  tx_stb_q <= 1'b0;
                  abort_q  <= 1'b1;
                  state_q  <= ST_CHECK;
               end else if (tx_stb_q) begin
                  if (sent_q == count_q) begin
                     // Last strobe just went out; no trailing gap.
                     tx_stb_q    <= 1'b0;
                     drain_cnt_q <= TW'(0);
                     state_q     <= ST_DRAIN;
                  end else if (gap_q == C_ZERO) begin
                     tx_stb_q <= 1'b1;
                     sent_q   <= sent_q + C_ONE;
                  end else begin
                     tx_stb_q  <= 1'b0;
                     gap_cnt_q <= C_ZERO;
                  end
               end else begin
                  if (gap_cnt_q == (gap_q - C_ONE)) begin
                     tx_stb_q  <= 1'b1;
                     sent_q    <= sent_q + C_ONE;
                     gap_cnt_q <= C_ZERO;
                  end else begin
                     gap_cnt_q <= gap_cnt_q + C_ONE;
                  end
               end
            end

            ST_DRAIN: begin
               if (abort_s) begin
                  abort_q <= 1'b1;
                  state_q <= ST_CHECK;
               end else if (rx_cnt_q >= count_q) begin
                  // Count reached takes priority over a coincident timeout.
                  state_q <= ST_CHECK;
               end else if (drain_cnt_q == TO_LAST) begin
                  timeout_q <= 1'b1;
                  state_q   <= ST_CHECK;
               end else begin
                  drain_cnt_q <= drain_cnt_q + TW'(1);
               end
            end

            ST_CHECK: begin
               // The checker has registered the final strobe by now.
               if (zero_q) begin
                  errors_q <= 5'b00001;
                  pass_q   <= 1'b0;
               end else begin
                  errors_q <= bus.rx_errors_i;
                  pass_q   <= (bus.rx_errors_i == 5'b00000) && !timeout_q && !abort_q
                              && (rx_cnt_q == count_q);
               end
               done_q  <= 1'b1;
               state_q <= ST_DONE;
            end

            ST_DONE: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end

            default: begin
               chk_rst_q <= 1'b0;
               tx_stb_q  <= 1'b0;
               busy_q    <= 1'b0;
               state_q   <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.chk_rst_o  = chk_rst_q;
   assign bus.seed_o     = seed_q;
   assign bus.tx_stb_o   = tx_stb_q;
   assign bus.busy_o     = busy_q;
   assign bus.done_o     = done_q;
   assign bus.pass_o     = pass_q;
   assign bus.timeout_o  = timeout_q;
   assign bus.errors_o   = errors_q;
   assign bus.rx_count_o = rx_cnt_q;

endmodule

// File: tb/tb_loop_test_ctrl.sv
// Testbench for loop_test_ctrl: randomized loopback stimulus, a schedule-based
// reference model checked every cycle, and literal expectations for the
// directed scenarios. DUT built with RST_CYCLES=4, TIMEOUT=16.
module tb_loop_test_ctrl;
   localparam int DW  = 8;
   localparam int CW  = 16;
   localparam int RST = 4;
   localparam int TO  = 16;
   localparam int CMAXV = (1 << CW) - 1;

   logic clk = 1'b0;
   logic rst_i;
   always #5 clk = ~clk;

   loop_test_ctrl_if #(.DWIDTH(DW), .CWIDTH(CW)) bus ();

   loop_test_ctrl #(.DWIDTH(DW), .CWIDTH(CW), .RST_CYCLES(RST), .TIMEOUT(TO)) dut (
      .clk_i (clk),
      .rst_i (rst_i),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   bit model_ok = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference model (schedule arithmetic) ----------------
   bit          m_act, m_zero, m_end_set, m_to, m_abort;
   int          m_e, m_first, m_last, m_end, m_cnt, m_gap, m_rx;
   logic        e_chk, e_tx, e_busy, e_done, e_pass, e_to;
   logic [4:0]  e_err;
   logic [CW-1:0] e_rx;
   logic [DW-1:0] e_seed;

   initial begin
      int c, p;
      m_act = 0;
      forever begin
         @(posedge clk);
         cyc++;
         c = cyc;
         p = c - 1;
         if (rst_i) begin
            m_act = 0;
            e_chk = 0; e_tx = 0; e_busy = 0; e_done = 0; e_pass = 0; e_to = 0;
            e_err = 0; e_rx = 0; e_seed = 0;
         end else if (!m_act) begin
            e_done = 0; e_chk = 0; e_tx = 0; e_busy = 0;
            if (bus.start_i) begin
               m_act = 1;
               m_e = c;
               m_cnt = int'(bus.count_i);
               m_gap = int'(bus.gap_i);
               m_first = c + RST;
               m_last = m_first + (m_cnt - 1) * (m_gap + 1);
               m_zero = (m_cnt == 0);
               m_end_set = m_zero;
               m_end = c - 1;
               m_to = 0; m_abort = 0; m_rx = 0;
               e_seed = bus.seed_i;
               e_pass = 0; e_to = 0; e_err = 0; e_rx = 0;
               e_busy = 1;
               e_chk = !m_zero;
            end
         end else begin
            if (!m_end_set && p >= m_first) begin
`ifdef LOOP_TEST_STOP_ON_ERR_EN
               if (bus.rx_errors_i[1]) begin
                  m_end_set = 1; m_end = p; m_abort = 1;
               end
`endif
               if (!m_end_set && p > m_last) begin
                  if (m_rx >= m_cnt) begin
                     m_end_set = 1; m_end = p;
                  end else if (p == m_last + TO) begin
                     m_end_set = 1; m_end = p; m_to = 1; e_to = 1;
                  end
               end
            end
            if (p >= m_first && (!m_end_set || p <= m_end) && bus.rx_stb_i && m_rx < CMAXV)
               m_rx++;
            e_done = 0;
            if (m_end_set && p == m_end + 1) begin
               e_err  = m_zero ? 5'b00001 : bus.rx_errors_i;
               e_pass = !m_zero && (bus.rx_errors_i == 5'd0) && !m_to && !m_abort && (m_rx == m_cnt);
               e_done = 1;
            end
            if (m_end_set && p == m_end + 2) m_act = 0;
            e_busy = m_act;
            e_chk  = m_act && !m_zero && (c >= m_e) && (c < m_e + RST);
            e_tx   = m_act && !m_zero && (c >= m_first) && ((c - m_first) % (m_gap + 1) == 0)
                     && ((c - m_first) / (m_gap + 1) < m_cnt) && (!m_end_set || c <= m_end);
            e_rx   = CW'(m_rx);
         end
         model_ok = 1;
      end
   end

   // ---------------- per-cycle compare and event log ----------------
   int tx_log[$];
   int done_log[$];

   initial begin
      forever begin
         @(negedge clk);
         if (model_ok) begin
            chk("chk_rst_o",  32'(bus.chk_rst_o),  32'(e_chk));
            chk("tx_stb_o",   32'(bus.tx_stb_o),   32'(e_tx));
            chk("busy_o",     32'(bus.busy_o),     32'(e_busy));
            chk("done_o",     32'(bus.done_o),     32'(e_done));
            chk("pass_o",     32'(bus.pass_o),     32'(e_pass));
            chk("timeout_o",  32'(bus.timeout_o),  32'(e_to));
            chk("errors_o",   32'(bus.errors_o),   32'(e_err));
            chk("rx_count_o", 32'(bus.rx_count_o), 32'(e_rx));
            chk("seed_o",     32'(bus.seed_o),     32'(e_seed));
            if (bus.tx_stb_o === 1'b1) tx_log.push_back(cyc);
            if (bus.done_o === 1'b1) done_log.push_back(cyc);
         end
      end
   end

   // ---------------- stimulus ----------------
   int policy, keep, rx_ret, tx_seen;

   task automatic step();
      logic tx_now;
      tx_now = (bus.tx_stb_o === 1'b1);
      if (tx_now) tx_seen++;
      @(posedge clk);
      #1;
      case (policy)
         0: bus.rx_stb_i = tx_now;
         1: begin
            bus.rx_stb_i = tx_now && (rx_ret < keep);
            if (bus.rx_stb_i) rx_ret++;
         end
         2: bus.rx_stb_i = tx_now ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 19) == 0);
         3: begin
            bus.rx_stb_i = tx_now;
            if (tx_seen >= 3) bus.rx_errors_i = 5'b00010;
         end
         default: bus.rx_stb_i = 1'b0;
      endcase
   endtask

   // Runs one test; s is chosen so that spec cycle number = log cycle - s.
   task automatic run_test(input int seed, input int cnt, input int gap, input int pol,
                           input int kp, input int ev, input int pulse_at,
                           output int s, output int ntx, output int ftx, output int dcyc);
      int t0, d0;
      policy = pol; keep = kp; rx_ret = 0; tx_seen = 0;
      bus.rx_errors_i = 5'(ev);
      t0 = tx_log.size();
      d0 = done_log.size();
      bus.seed_i = DW'(seed);
      bus.count_i = CW'(cnt);
      bus.gap_i = CW'(gap);
      bus.start_i = 1'b1;
      step();
      s = cyc - 1;
      bus.start_i = 1'b0;
      for (int i = 1; i < 400 && done_log.size() == d0; i++) begin
         bus.start_i = (i == pulse_at);
         step();
      end
      bus.start_i = 1'b0;
      dcyc = -1;
      if (done_log.size() == d0) chk("done_within_bound", 32'd0, 32'd1);
      else dcyc = done_log[d0] - s;
      ntx = tx_log.size() - t0;
      ftx = (ntx > 0) ? tx_log[t0] - s : -1;
      step();
      bus.rx_errors_i = 5'b00000;
   endtask

   initial begin
      int s, ntx, ftx, dcyc, t0, d0, cnt;
      rst_i = 1'b1;
      bus.start_i = 1'b0; bus.seed_i = '0; bus.count_i = '0; bus.gap_i = '0;
      bus.rx_stb_i = 1'b0; bus.rx_errors_i = 5'b00000;
      policy = 0; keep = 0; rx_ret = 0; tx_seen = 0;
      repeat (3) step();
      rst_i = 1'b0;
      chk("reset_busy", 32'(bus.busy_o), 32'd0);
      chk("reset_seed", 32'(bus.seed_o), 32'd0);
      chk("reset_rxcnt", 32'(bus.rx_count_o), 32'd0);
      step();

      // Clean loop
      run_test(8'h10, 5, 0, 0, 0, 0, -1, s, ntx, ftx, dcyc);
      chk("clean_ntx", 32'(ntx), 32'd5);
      chk("clean_first_tx", 32'(ftx), 32'd5);
      chk("clean_done_cyc", 32'(dcyc), 32'd13);
      chk("clean_pass", 32'(bus.pass_o), 32'd1);
      chk("clean_rxcnt", 32'(bus.rx_count_o), 32'd5);
      chk("clean_errors", 32'(bus.errors_o), 32'd0);
      chk("clean_timeout", 32'(bus.timeout_o), 32'd0);

      // Gap pacing
      t0 = tx_log.size();
      run_test(8'h22, 3, 2, 0, 0, 0, -1, s, ntx, ftx, dcyc);
      chk("gap_ntx", 32'(ntx), 32'd3);
      for (int k = 0; k < 3 && k < ntx; k++) chk("gap_tx_cycle", 32'(tx_log[t0 + k] - s), 32'(5 + 3 * k));
      chk("gap_done_cyc", 32'(dcyc), 32'd15);

      // Lost data -> timeout
      run_test(8'h33, 4, 0, 1, 3, 0, -1, s, ntx, ftx, dcyc);
      chk("lost_done_cyc", 32'(dcyc), 32'd26);
      chk("lost_timeout", 32'(bus.timeout_o), 32'd1);
      chk("lost_pass", 32'(bus.pass_o), 32'd0);
      chk("lost_rxcnt", 32'(bus.rx_count_o), 32'd3);

      // Zero count
      run_test(8'h44, 0, 0, 0, 0, 0, -1, s, ntx, ftx, dcyc);
      chk("zero_done_cyc", 32'(dcyc), 32'd2);
      chk("zero_ntx", 32'(ntx), 32'd0);
      chk("zero_errors", 32'(bus.errors_o), 32'd1);
      chk("zero_pass", 32'(bus.pass_o), 32'd0);

      // Start pulsed while busy is ignored
      run_test(8'h55, 8, 0, 0, 0, 0, 6, s, ntx, ftx, dcyc);
      chk("busy_start_ntx", 32'(ntx), 32'd8);
      chk("busy_start_pass", 32'(bus.pass_o), 32'd1);

      // Reset mid-test
      d0 = done_log.size();
      policy = 0; tx_seen = 0;
      bus.seed_i = 8'h66; bus.count_i = CW'(6); bus.gap_i = CW'(1);
      bus.start_i = 1'b1;
      step();
      bus.start_i = 1'b0;
      for (int i = 0; i < 50 && tx_seen < 2; i++) step();
      chk("midrst_two_strobes", 32'(tx_seen), 32'd2);
      rst_i = 1'b1;
      step();
      rst_i = 1'b0;
      chk("midrst_busy", 32'(bus.busy_o), 32'd0);
      chk("midrst_seed", 32'(bus.seed_o), 32'd0);
      chk("midrst_rxcnt", 32'(bus.rx_count_o), 32'd0);
      repeat (4) step();
      chk("midrst_no_done", 32'(done_log.size() - d0), 32'd0);
      run_test(8'h77, 5, 0, 0, 0, 0, -1, s, ntx, ftx, dcyc);
      chk("after_rst_done_cyc", 32'(dcyc), 32'd13);
      chk("after_rst_pass", 32'(bus.pass_o), 32'd1);

      // Value-mismatch error raised after the 3rd strobe
      run_test(8'h88, 10, 2, 3, 0, 0, -1, s, ntx, ftx, dcyc);
`ifdef LOOP_TEST_STOP_ON_ERR_EN
      chk("stoperr_ntx", 32'(ntx), 32'd3);
`else
      chk("stoperr_ntx", 32'(ntx), 32'd10);
`endif
      chk("stoperr_pass", 32'(bus.pass_o), 32'd0);
      chk("stoperr_err1", 32'(bus.errors_o[1]), 32'd1);

      // Randomized tests, checked by the model every cycle
      for (int t = 0; t < 25; t++) begin
         int pol, ev;
         cnt = $urandom_range(0, 12);
         pol = $urandom_range(0, 2);
         ev  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 31) : 0;
         run_test($urandom_range(0, 255), cnt, $urandom_range(0, 3), pol,
                  $urandom_range(0, 12), ev, $urandom_range(1, 40), s, ntx, ftx, dcyc);
         repeat ($urandom_range(0, 3)) step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
